// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The arbiter uses the slave modport. The clients and the transmitter use master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_Req;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   o_Grant;
    logic [NUM_REQ-1:0]   o_Done;
    logic                 o_Err;
    logic                 o_Busy;
    logic [2:0]           o_Owner;
    logic                 o_Tx_DV;
    logic [7:0]           o_Tx_Byte;
    logic                 i_Tx_Active;
    logic                 i_Tx_Done;

    // Arbiter view
    modport slave (
        input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        output o_Grant, o_Done, o_Err, o_Busy, o_Owner, o_Tx_DV, o_Tx_Byte
    );

    // Client / transmitter view
    modport master (
        output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Grant, o_Done, o_Err, o_Busy, o_Owner, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters.
// Only one byte is in flight at a time. A watchdog abandons a byte when the
// transmitter never starts or never finishes.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int WD_LIMIT = 12 * CLKS_PER_BIT;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    // Count value that expires on the next counted cycle.
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(WD_LIMIT - 1);
    localparam logic [WD_W-1:0]    WD_MAX  = WD_W'(WD_LIMIT);
    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
    localparam logic [2:0]         LAST_IX = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [WD_W-1:0]    wd_reg, wd_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic               err_reg, err_next;
    logic               dv_reg, dv_next;
    logic [7:0]         byte_reg, byte_next;
    logic [2:0]         owner_reg, owner_next;

    // Requests and bytes are padded to 8 lanes so that a 3-bit index always fits.
    logic [7:0] req_ext;
    logic [7:0] byte_arr [8];
    // cand_idx[i] is the requester examined at priority position i, starting at ptr.
    logic [2:0] cand_idx [NUM_REQ];
    logic       found;
    logic [2:0] win_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < NUM_REQ) begin : g_used
                assign req_ext[gi]  = bus.i_Req[gi];
                assign byte_arr[gi] = bus.i_Req_Byte[8*gi +: 8];
            end else begin : g_unused
                assign req_ext[gi]  = 1'b0;
                assign byte_arr[gi] = 8'h00;
            end
        end

        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [3:0] sum;
            assign sum          = {1'b0, ptr_reg} + 4'(gi);
            assign cand_idx[gi] = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
        end
    endgenerate

    // The first active request at or after the pointer wins.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_ext[cand_idx[i]]) begin
                found   = 1'b1;
                win_idx = cand_idx[i];
            end
        end
    end

    // Next state, watchdog and registered outputs.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        wd_next    = wd_reg;
        grant_next = '0;
        done_next  = '0;
        err_next   = 1'b0;
        dv_next    = 1'b0;
        byte_next  = byte_reg;
        owner_next = owner_reg;

        unique case (state_reg)
            IDLE: begin
                // Grant only when the transmitter is idle. After a reset in mid-frame,
                // this waits until the transmitter finishes the frame.
                if (!bus.i_Tx_Active && !bus.i_Tx_Done && found) begin
                    grant_next = ONE << win_idx;
                    dv_next    = 1'b1;
                    byte_next  = byte_arr[win_idx];
                    owner_next = win_idx;
                    ptr_next   = (win_idx == LAST_IX) ? 3'd0 : win_idx + 3'd1;
                    wd_next    = '0;
                    state_next = WAIT_START;
                end
            end

            WAIT_START: begin
                if (wd_reg >= WD_LAST) begin
                    wd_next    = WD_MAX;
                    err_next   = 1'b1;
                    state_next = GAP;
                end else begin
                    wd_next = wd_reg + 1'b1;
                    if (bus.i_Tx_Active) begin
                        state_next = WAIT_DONE;
                    end
                end
            end

            WAIT_DONE: begin
                // If done and watchdog expiry occur in the same cycle, done wins.
                if (bus.i_Tx_Done) begin
                    done_next  = ONE << owner_reg;
                    state_next = GAP;
                end else if (wd_reg >= WD_LAST) begin
                    wd_next    = WD_MAX;
                    err_next   = 1'b1;
                    state_next = GAP;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end

            GAP: begin
                // Wait for the done signal, which can stay high for 2 cycles, to go low.
                // Then the done is counted once and the next DV cannot start mid-frame.
                if (!bus.i_Tx_Done && !bus.i_Tx_Active) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 3'd0;
            wd_reg    <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            err_reg   <= 1'b0;
            dv_reg    <= 1'b0;
            byte_reg  <= 8'h00;
            owner_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            wd_reg    <= wd_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            dv_reg    <= dv_next;
            byte_reg  <= byte_next;
            owner_reg <= owner_next;
        end
    end

    assign bus.o_Grant   = grant_reg;
    assign bus.o_Done    = done_reg;
    assign bus.o_Err     = err_reg;
    assign bus.o_Busy    = (state_reg != IDLE);
    assign bus.o_Owner   = owner_reg;
    assign bus.o_Tx_DV   = dv_reg;
    assign bus.o_Tx_Byte = byte_reg;
endmodule
